// File: rtl/dice_score.sv
// Score-keeping core for the two-player dice game: arms on both button presses,
// holds each round result, then commits scores and tracks rounds/game over.
// Optional build macro TIE_REPLAY_EN: tie rounds are replayed (round counter unchanged).
module dice_score #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int MAX_ROUNDS  = 5,
  parameter int WIN_SCORE   = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start1,
  input  logic       start2,
  input  logic [3:0] dice1,
  input  logic [3:0] dice2,
  output logic [3:0] state1,
  output logic [3:0] state2,
  output logic       times,
  output logic       is_final,
  output logic       finish
);

  // state    | meaning
  // ST_ARM   | waiting for both players to press; resolves when both flags set
  // ST_HOLD  | result displayed, counting HOLD_CYCLES before commit
  // ST_OVER  | game over, scores frozen until rst
  typedef enum logic [1:0] {ST_ARM, ST_HOLD, ST_OVER} phase_t;

  localparam logic [27:0] HOLD_LAST  = 28'(HOLD_CYCLES - 1);
  localparam logic [3:0]  LAST_ROUND = 4'(MAX_ROUNDS - 1);
  localparam logic [3:0]  NUM_ROUNDS = 4'(MAX_ROUNDS);

  phase_t      phase;
  logic        start1_meta, start1_sync, start1_before;
  logic        start2_meta, start2_sync, start2_before;
  logic        flag1, flag2;
  logic [27:0] cnt;
  logic [3:0]  difference;
  logic [3:0]  state1_tmp, state2_tmp;
  logic [3:0]  round_cnt;
`ifdef TIE_REPLAY_EN
  logic        tie;
`endif

  logic       press1, press2, sign;
  logic [3:0] diff_now;
  logic [4:0] sum1, sum2;
  logic [3:0] sat1, sat2;
  logic [3:0] round_next;
  logic       finish_next;

  assign press1   = start1_sync & ~start1_before;
  assign press2   = start2_sync & ~start2_before;
  assign sign     = flag1 & flag2;
  assign diff_now = (dice1 > dice2) ? (dice1 - dice2) : (dice2 - dice1);
  assign sum1     = {1'b0, state1} + {1'b0, diff_now};
  assign sum2     = {1'b0, state2} + {1'b0, diff_now};
  assign sat1     = sum1[4] ? 4'hF : sum1[3:0];
  assign sat2     = sum2[4] ? 4'hF : sum2[3:0];
  assign is_final = (round_cnt == LAST_ROUND);

`ifdef TIE_REPLAY_EN
  assign round_next = tie ? round_cnt : round_cnt + 4'd1;
`else
  assign round_next = round_cnt + 4'd1;
`endif

  assign finish_next = (round_next == NUM_ROUNDS) ||
                       (int'(state1_tmp) >= WIN_SCORE) ||
                       (int'(state2_tmp) >= WIN_SCORE);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase         <= ST_ARM;
      start1_meta   <= 1'b0;
      start1_sync   <= 1'b0;
      start1_before <= 1'b0;
      start2_meta   <= 1'b0;
      start2_sync   <= 1'b0;
      start2_before <= 1'b0;
      flag1         <= 1'b0;
      flag2         <= 1'b0;
      cnt           <= '0;
      difference    <= '0;
      state1_tmp    <= '0;
      state2_tmp    <= '0;
      state1        <= '0;
      state2        <= '0;
      round_cnt     <= '0;
      times         <= 1'b0;
      finish        <= 1'b0;
`ifdef TIE_REPLAY_EN
      tie           <= 1'b0;
`endif
    end else begin
      start1_meta   <= start1;
      start1_sync   <= start1_meta;
      start1_before <= start1_sync;
      start2_meta   <= start2;
      start2_sync   <= start2_meta;
      start2_before <= start2_sync;

      case (phase)
        ST_ARM: begin
          if (sign) begin
            difference <= diff_now;
            state1_tmp <= (dice1 > dice2) ? sat1 : state1;
            state2_tmp <= (dice2 > dice1) ? sat2 : state2;
`ifdef TIE_REPLAY_EN
            tie        <= (dice1 == dice2);
`endif
            flag1      <= 1'b0;
            flag2      <= 1'b0;
            cnt        <= '0;
            times      <= 1'b1;
            phase      <= ST_HOLD;
          end else begin
            if (press1) flag1 <= 1'b1;
            if (press2) flag2 <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            state1    <= state1_tmp;
            state2    <= state2_tmp;
            round_cnt <= round_next;
            times     <= 1'b0;
            cnt       <= '0;
            finish    <= finish_next;
            phase     <= finish_next ? ST_OVER : ST_ARM;
          end else begin
            cnt <= cnt + 28'd1;
          end
        end
        ST_OVER: ;
        default: phase <= ST_ARM;
      endcase
    end
  end

endmodule

// File: tb/tb_dice_score.sv
// Directed self-checking bench for dice_score: rounds, hold timing, ignored presses,
// game length, saturation/early finish and reset mid-hold.
module tb_dice_score;
  localparam int HOLD = 1000;
  localparam int MAXR = 5;
  localparam int WIN  = 15;

  logic       clk = 1'b0;
  logic       rst, start1, start2;
  logic [3:0] dice1, dice2;
  logic [3:0] state1, state2;
  logic       times, is_final, finish;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_s1, exp_s2, exp_rounds, exp_diff;
  bit exp_finish;

  dice_score #(.HOLD_CYCLES(HOLD), .MAX_ROUNDS(MAXR), .WIN_SCORE(WIN)) dut (
    .clk(clk), .rst(rst), .start1(start1), .start2(start2),
    .dice1(dice1), .dice2(dice2), .state1(state1), .state2(state2),
    .times(times), .is_final(is_final), .finish(finish)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_s1"}, state1, exp_s1);
    check_eq({tag, "_s2"}, state2, exp_s2);
    check_eq({tag, "_finish"}, finish, exp_finish);
    check_eq({tag, "_is_final"}, is_final, exp_rounds == MAXR - 1);
  endtask

  task automatic model_reset();
    exp_s1 = 0; exp_s2 = 0; exp_rounds = 0; exp_finish = 0;
  endtask

  // mode 0: start1 then start2 pulses; 1: simultaneous; 2: start1 held 20 cycles
  task automatic press(input int mode);
    case (mode)
      1: begin start1 = 1; start2 = 1; tick(); start1 = 0; start2 = 0; end
      2: begin
        start1 = 1;
        repeat (20) tick();
        start1 = 0; tick(); tick();
        start2 = 1; tick(); start2 = 0;
      end
      default: begin
        start1 = 1; tick(); start1 = 0; tick(); tick();
        start2 = 1; tick(); start2 = 0;
      end
    endcase
  endtask

  task automatic play_round(input logic [3:0] d1, input logic [3:0] d2, input int mode);
    bit seen;
    bit extra;
    int n;
    dice1 = d1; dice2 = d2;
    press(mode);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (times) seen = 1;
    end
    if (exp_finish) begin
      check_eq("no_resolve_after_finish", seen, 0);
      check_outputs("frozen");
      return;
    end
    check_eq("resolve_seen", seen, 1);
    if (!seen) return;
    n = 0;
    while (times && n < 3 * HOLD) begin
      n++;
      if (n == 6) begin start1 = 1; start2 = 1; end
      if (n == 7) begin start1 = 0; start2 = 0; end
      tick();
    end
    check_eq("hold_len", n, HOLD);
    exp_diff = (d1 > d2) ? int'(d1) - int'(d2) : int'(d2) - int'(d1);
    check_eq("difference", dut.difference, exp_diff);
    if (d1 > d2) exp_s1 = (exp_s1 + exp_diff > 15) ? 15 : exp_s1 + exp_diff;
    if (d2 > d1) exp_s2 = (exp_s2 + exp_diff > 15) ? 15 : exp_s2 + exp_diff;
`ifdef TIE_REPLAY_EN
    if (d1 != d2) exp_rounds++;
`else
    exp_rounds++;
`endif
    if (exp_rounds >= MAXR || exp_s1 >= WIN || exp_s2 >= WIN) exp_finish = 1;
    check_outputs("commit");
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (times) extra = 1;
    end
    check_eq("no_extra_resolve", extra, 0);
  endtask

  initial begin
    rst = 1; start1 = 0; start2 = 0; dice1 = 0; dice2 = 0;
    model_reset();
    repeat (3) tick();
    rst = 0;
    tick();
    check_eq("rst_times", times, 0);
    check_outputs("rst");

    // Game: 5/3, 5/3, 2/6, 4/4, 2/6 then a sixth pair
    play_round(4'd5, 4'd3, 0);
    check_eq("r1_s1_hand", state1, 2);
    play_round(4'd5, 4'd3, 1);
    play_round(4'd2, 4'd6, 0);
    play_round(4'd4, 4'd4, 0);
    play_round(4'd2, 4'd6, 0);
`ifndef TIE_REPLAY_EN
    check_eq("game_s1_hand", state1, 4);
    check_eq("game_s2_hand", state2, 8);
    check_eq("game_finish_hand", finish, 1);
`endif
    play_round(4'd5, 4'd3, 0);

    // Reset mid-hold with a nonzero score
    rst = 1; tick(); rst = 0; tick();
    model_reset();
    play_round(4'd6, 4'd1, 0);
    dice1 = 4'd6; dice2 = 4'd1;
    press(0);
    for (int i = 0; i < 40 && !times; i++) tick();
    check_eq("midhold_times", times, 1);
    repeat (10) tick();
    rst = 1; tick(); rst = 0;
    model_reset();
    check_eq("midhold_rst_times", times, 0);
    check_outputs("midhold_rst");

    // Saturation and early finish: 9 then 9 more caps at 15
    play_round(4'd10, 4'd1, 2);
    play_round(4'd10, 4'd1, 1);
    check_eq("sat_s1_hand", state1, 15);
    check_eq("sat_finish_hand", finish, 1);
    play_round(4'd1, 4'd9, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
